// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and the raster position type.
// Imported by the timing generator and by the downstream pixel colour stage.
package vga_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam logic SYNC_ACTIVE = 1'b0;

  localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int POS_W = 10;
  typedef logic [POS_W-1:0] pos_t;

  // Inclusive range test on a raster coordinate.
  function automatic logic in_range(input pos_t p, input int lo, input int hi);
    return (int'(p) >= lo) && (int'(p) <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle between the timing generator and the pixel colour stage.
// The consumer side also supplies the pixel-clock enable.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic       ce;
  pos_t       hpos;
  pos_t       vpos;
  logic       hsync;
  logic       vsync;
  logic       visible;
  logic       line_start;
  logic       frame_start;
  logic [9:0] frame_count;

  modport master (
    input  ce,
    output hpos, vpos, hsync, vsync, visible, line_start, frame_start, frame_count
  );

  modport slave (
    output ce,
    input  hpos, vpos, hsync, vsync, visible, line_start, frame_start, frame_count
  );

endinterface

// File: rtl/wrap_counter.sv
// Modulo-N counter with enable; resets to N-1 so the first enabled edge wraps.
// q_nxt is the value q takes on the coming edge, for flag look-ahead.
module wrap_counter
  import vga_pkg::*;
#(
  parameter int N = 800
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output pos_t q,
  output pos_t q_nxt,
  output logic wrap
);

  logic at_max;

  assign at_max = (q == pos_t'(N - 1));
  assign wrap   = en & at_max;

  always_comb begin
    q_nxt = q;
    if (en) q_nxt = at_max ? '0 : q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= pos_t'(N - 1);
    else     q <= q_nxt;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: position counters, syncs, visible flag, line/frame strobes
// and frame counter, all registered and aligned with hpos/vpos.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_DISPLAY   = vga_pkg::H_DISPLAY,
  parameter int   H_FRONT     = vga_pkg::H_FRONT,
  parameter int   H_SYNC      = vga_pkg::H_SYNC,
  parameter int   H_BACK      = vga_pkg::H_BACK,
  parameter int   V_DISPLAY   = vga_pkg::V_DISPLAY,
  parameter int   V_FRONT     = vga_pkg::V_FRONT,
  parameter int   V_SYNC      = vga_pkg::V_SYNC,
  parameter int   V_BACK      = vga_pkg::V_BACK,
  parameter logic SYNC_ACTIVE = vga_pkg::SYNC_ACTIVE
) (
  input logic               clk,
  input logic               rst,
  vga_timing_gen_if.master  vif
);

  localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  pos_t       h_q, h_nxt, v_q, v_nxt;
  logic       h_wrap, v_wrap;
  logic       hsync_r, vsync_r, visible_r, line_start_r, frame_start_r;
  logic [9:0] frame_count_r;

  wrap_counter #(.N(H_TOTAL)) u_hcnt (
    .clk   (clk),
    .rst   (rst),
    .en    (vif.ce),
    .q     (h_q),
    .q_nxt (h_nxt),
    .wrap  (h_wrap)
  );

  // v_wrap therefore marks the edge that lands on (0,0).
  wrap_counter #(.N(V_TOTAL)) u_vcnt (
    .clk   (clk),
    .rst   (rst),
    .en    (vif.ce & h_wrap),
    .q     (v_q),
    .q_nxt (v_nxt),
    .wrap  (v_wrap)
  );

  // Flags come from the next-state counters so they line up with hpos/vpos.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_r       <= ~SYNC_ACTIVE;
      vsync_r       <= ~SYNC_ACTIVE;
      visible_r     <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_count_r <= '0;
    end else begin
      line_start_r  <= h_wrap;
      frame_start_r <= v_wrap;
      if (vif.ce) begin
        hsync_r   <= in_range(h_nxt, H_SYNC_START, H_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_r   <= in_range(v_nxt, V_SYNC_START, V_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        visible_r <= (int'(h_nxt) < H_DISPLAY) && (int'(v_nxt) < V_DISPLAY);
        if (v_wrap) frame_count_r <= frame_count_r + 1'b1;
      end
    end
  end

  assign vif.hpos        = h_q;
  assign vif.vpos        = v_q;
  assign vif.hsync       = hsync_r;
  assign vif.vsync       = vsync_r;
  assign vif.visible     = visible_r;
  assign vif.line_start  = line_start_r;
  assign vif.frame_start = frame_start_r;
  assign vif.frame_count = frame_count_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (8x6) so frame-count wrap fits.
// Reference: position derived from the count of ce edges since reset.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int   HD = 4, HF = 1, HS = 2, HB = 1;
  localparam int   VD = 2, VF = 1, VS = 2, VB = 1;
  localparam int   HT = HD + HF + HS + HB;
  localparam int   VT = VD + VF + VS + VB;
  localparam int   FT = HT * VT;
  localparam logic SA = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   n = 0;
  bit   last_ce = 1'b0;
  logic [34:0] obs, exp_v;

  vga_timing_gen_if vif();

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(SA)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vif (vif.master)
  );

  always #5 clk = ~clk;

  assign obs = {vif.hpos, vif.vpos, vif.hsync, vif.vsync, vif.visible,
                vif.line_start, vif.frame_start, vif.frame_count};

  // Expected output vector after cnt enabled edges since reset.
  function automatic logic [34:0] model(input int cnt, input bit lce);
    int l, h, v;
    logic hs, vs, vis, ls, fs;
    logic [9:0] fc;
    if (cnt == 0) return {10'(HT - 1), 10'(VT - 1), ~SA, ~SA, 3'b000, 10'd0};
    l   = (cnt - 1) % FT;
    h   = l % HT;
    v   = l / HT;
    hs  = (h >= HD + HF && h < HD + HF + HS) ? SA : ~SA;
    vs  = (v >= VD + VF && v < VD + VF + VS) ? SA : ~SA;
    vis = (h < HD) && (v < VD);
    ls  = lce && (h == 0);
    fs  = ls && (v == 0);
    fc  = 10'(((cnt - 1) / FT + 1) % 1024);
    return {10'(h), 10'(v), hs, vs, vis, ls, fs, fc};
  endfunction

  task automatic tick(input bit c);
    vif.ce = c;
    @(posedge clk);
    if (c && !rst) n++;
    last_ce = c && !rst;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    n = 0;
    last_ce = 1'b0;
    tick(1'b1);
    tick(1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    vif.ce = 1'b1;
    #2;
    tick(1'b1);
    tick(1'b1);
    exp_v = model(0, 1'b0);
    total++;
    if (obs !== exp_v) begin
      bad++; $display("FAIL reset_state got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_first_edge();
    @(negedge clk);
    rst = 1'b0;
    tick(1'b1);
    exp_v = model(n, last_ce);
    total++;
    if (obs !== exp_v) begin
      bad++; $display("FAIL first_edge got=%h want=%h", obs, exp_v);
    end
    total++;
    if ({vif.visible, vif.line_start, vif.frame_start, vif.frame_count} !== {3'b111, 10'd1}) begin
      bad++; $display("FAIL first_edge_flags got=%b%b%b fc=%0d want=111 fc=1",
                      vif.visible, vif.line_start, vif.frame_start, vif.frame_count);
    end
    tick(1'b1);
    total++;
    if ({vif.line_start, vif.frame_start} !== 2'b00) begin
      bad++; $display("FAIL strobe_drop got=%b%b want=00", vif.line_start, vif.frame_start);
    end
  endtask

  // Any 2*FT consecutive enabled cycles visit each raster position exactly twice.
  task automatic test_frame();
    int hs_n = 0, vs_n = 0, vis_n = 0, ls_n = 0, fs_n = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      tick(1'b1);
      exp_v = model(n, last_ce);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL frame cyc=%0d got=%h want=%h", i, obs, exp_v);
      end
      if (vif.hsync == SA) hs_n++;
      if (vif.vsync == SA) vs_n++;
      if (vif.visible) vis_n++;
      if (vif.line_start) ls_n++;
      if (vif.frame_start) fs_n++;
    end
    total++;
    if ({hs_n, vs_n, vis_n, ls_n, fs_n} !== {2 * HS * VT, 2 * VS * HT, 2 * HD * VD, 2 * VT, 2}) begin
      bad++; $display("FAIL frame_counts got hs=%0d vs=%0d vis=%0d ls=%0d fs=%0d want %0d %0d %0d %0d 2",
                      hs_n, vs_n, vis_n, ls_n, fs_n, 2 * HS * VT, 2 * VS * HT, 2 * HD * VD, 2 * VT);
    end
  endtask

  task automatic test_random_ce();
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)));
      exp_v = model(n, last_ce);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL random_ce cyc=%0d got=%h want=%h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_half_rate();
    int first = -1, second = -1;
    for (int i = 0; i < 6 * FT && second < 0; i++) begin
      tick(1'(i % 2));
      exp_v = model(n, last_ce);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL half_rate cyc=%0d got=%h want=%h", i, obs, exp_v);
      end
      if (vif.frame_start) begin
        if (first < 0) first = i;
        else second = i;
      end
    end
    total++;
    if (second < 0 || (second - first) !== 2 * FT) begin
      bad++; $display("FAIL half_rate_period got=%0d want=%0d", second - first, 2 * FT);
    end
  endtask

  task automatic test_async_reset();
    int k;
    k = $urandom_range(FT + 5, 2 * FT);
    for (int i = 0; i < k; i++) tick(1'b1);
    #3;
    rst = 1'b1;
    #1;
    n = 0;
    last_ce = 1'b0;
    exp_v = model(0, 1'b0);
    total++;
    if (obs !== exp_v) begin
      bad++; $display("FAIL async_reset after=%0d got=%h want=%h", k, obs, exp_v);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(1'b1);
    exp_v = model(n, last_ce);
    total++;
    if (obs !== exp_v || vif.frame_start !== 1'b1) begin
      bad++; $display("FAIL async_reset_restart got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_fc_wrap();
    do_reset();
    for (int i = 0; i < 1023 * FT + 1; i++) begin
      tick(1'b1);
      exp_v = model(n, last_ce);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL fc_run cyc=%0d got=%h want=%h", i, obs, exp_v);
      end
    end
    total++;
    if ({vif.frame_start, vif.frame_count} !== {1'b1, 10'd0}) begin
      bad++; $display("FAIL fc_wrap got fs=%b fc=%0d want fs=1 fc=0", vif.frame_start, vif.frame_count);
    end
    tick(1'b1);
    total++;
    if ({vif.frame_start, vif.frame_count} !== {1'b0, 10'd0}) begin
      bad++; $display("FAIL fc_hold got fs=%b fc=%0d want fs=0 fc=0", vif.frame_start, vif.frame_count);
    end
  endtask

  initial begin
    vif.ce = 1'b0;
    test_reset();
    test_first_edge();
    test_frame();
    test_random_ce();
    test_half_rate();
    test_async_reset();
    test_fc_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
